// File: rtl/glb_dma_pkg.sv
// Shared types and constants for the GLB DMA engine.
//   dma_state_e : engine FSM state encoding
//   DIR_*       : transfer direction encoding of the dir input
//   CH_*        : default GLB channel indices
//   sat_inc32   : saturating 32-bit increment for the optional statistics
package glb_dma_pkg;

    typedef enum logic [1:0] {IDLE, FWD, BWD, FINISH} dma_state_e;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_BWD = 1'b1;

    localparam int CH_IFMAP  = 0;
    localparam int CH_FILTER = 1;
    localparam int CH_BIAS   = 2;
    localparam int CH_PSUM   = 3;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/glb_dma_engine_fifo.sv
// Synchronous staging FIFO with show-ahead read data.
//   push/wdata : write one entry (ignored when full)
//   pop/rdata  : rdata is the head entry; pop consumes it (ignored when empty)
//   count      : entries held, 0..DEPTH
//   full/empty : derived from (AW+1)-bit wrap pointers
// DEPTH must be a power of 2, >= 4. Reset is synchronous, active-high.
module sync_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16
) (
    input  logic                       core_clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_WIDTH-1:0]      wdata,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;
    logic                  do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge core_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge core_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    // Same slot, different lap: the writer is a full buffer ahead.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/glb_dma_engine.sv
// DRAM <-> GLB block DMA engine (single clock domain).
// Moves words_num words between DRAM and one of NUM_CH GLB banks through a
// credit-controlled staging FIFO, so DRAM stalls and GLB read latency never
// drop data.
//   control : start, dir, ch_sel, base_address, words_num -> busy, done,
//             done_ch (one-hot), cfg_err
//   forward : dram_rd_req / dram_rd_valid / dram_rd_data -> glb_w_en,
//             glb_waddr, glb_wdata (registered, one cycle after the FIFO pop)
//   backward: glb_r_en / glb_raddr / glb_rdata (1-cycle latency) ->
//             dram_w_en, dram_wdata, dram_w_ready handshake
// Optional: define GLB_DMA_STATS_EN to add last_cycles / last_stall outputs.
// Reset is synchronous, active-high.
module glb_dma_engine
    import glb_dma_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 20,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  core_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  dir,
    input  logic [CH_W-1:0]       ch_sel,
    input  logic [ADDR_WIDTH-1:0] base_address,
    input  logic [ADDR_WIDTH-1:0] words_num,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_CH-1:0]     done_ch,
    output logic                  cfg_err,
    output logic                  dram_rd_req,
    input  logic                  dram_rd_valid,
    input  logic [DATA_WIDTH-1:0] dram_rd_data,
    output logic [NUM_CH-1:0]     glb_w_en,
    output logic [ADDR_WIDTH-1:0] glb_waddr,
    output logic [DATA_WIDTH-1:0] glb_wdata,
    output logic                  glb_r_en,
    output logic [ADDR_WIDTH-1:0] glb_raddr,
    input  logic [DATA_WIDTH-1:0] glb_rdata,
    output logic                  dram_w_en,
    output logic [DATA_WIDTH-1:0] dram_wdata,
    input  logic                  dram_w_ready
`ifdef GLB_DMA_STATS_EN
    ,
    output logic [31:0]           last_cycles,
    output logic [31:0]           last_stall
`endif
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int RD_LAT = 1;   // GLB read data latency in cycles

    typedef struct packed {
        logic [CH_W-1:0]       ch;
        logic [ADDR_WIDTH-1:0] base;
        logic [ADDR_WIDTH-1:0] words;
    } dma_cfg_t;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        return NUM_CH'(1) << ch;
    endfunction

    dma_state_e            state;
    dma_cfg_t              cfg;
    logic [ADDR_WIDTH-1:0] req_cnt, ret_cnt;
    logic [CNT_W-1:0]      outstanding;
    logic [RD_LAT:0]       vld_pipe;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_wdata, fifo_rdata;
    logic [CNT_W-1:0]      fifo_count;

    logic                  active, ch_ok, accept, more_req, credit_ok, issue;
    logic                  fwd_pop, bwd_pop, last_word;
    logic [CNT_W:0]        inflight;

    assign active   = (state == FWD) || (state == BWD);
    assign ch_ok    = int'(ch_sel) < NUM_CH;
    assign accept   = (state == IDLE) && start && ch_ok;
    assign more_req = req_cnt < cfg.words;
    // Every issued word owns a FIFO slot from request until pop, so the
    // FIFO can never be pushed while full.
    assign inflight  = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit_ok = (inflight < (CNT_W+1)'(FIFO_DEPTH)) && !fifo_full;
    assign issue     = active && more_req && credit_ok;

    assign dram_rd_req = issue && (state == FWD);
    assign glb_r_en    = issue && (state == BWD);
    assign glb_raddr   = glb_r_en ? cfg.base + req_cnt : '0;

    // GLB read returns track the strobe through a fixed-latency valid pipe.
    assign vld_pipe[0] = glb_r_en;
    always_ff @(posedge core_clk) begin
        if (reset) vld_pipe[RD_LAT:1] <= '0;
        else       vld_pipe[RD_LAT:1] <= vld_pipe[RD_LAT-1:0];
    end

    // DRAM returns outside FWD (e.g. stragglers after an abort) are dropped.
    assign fifo_push  = ((state == FWD) && dram_rd_valid) ||
                        ((state == BWD) && vld_pipe[RD_LAT]);
    assign fifo_wdata = (state == BWD) ? glb_rdata : dram_rd_data;

    assign fwd_pop    = (state == FWD) && !fifo_empty;
    assign dram_w_en  = (state == BWD) && !fifo_empty;
    assign dram_wdata = dram_w_en ? fifo_rdata : '0;
    assign bwd_pop    = dram_w_en && dram_w_ready;
    assign fifo_pop   = fwd_pop || bwd_pop;

    assign last_word  = (ret_cnt == cfg.words) && fifo_empty;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .core_clk (core_clk),
        .reset    (reset),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .wdata    (fifo_wdata),
        .rdata    (fifo_rdata),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge core_clk) begin
        if (reset) begin
            state       <= IDLE;
            cfg         <= '0;
            req_cnt     <= '0;
            ret_cnt     <= '0;
            outstanding <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            done_ch     <= '0;
            cfg_err     <= 1'b0;
            glb_w_en    <= '0;
            glb_waddr   <= '0;
            glb_wdata   <= '0;
        end else begin
            done     <= 1'b0;
            done_ch  <= '0;
            cfg_err  <= 1'b0;
            glb_w_en <= '0;
            case (state)
                IDLE: begin
                    if (start && !ch_ok) begin
                        cfg_err <= 1'b1;
                    end else if (accept) begin
                        cfg.ch      <= ch_sel;
                        cfg.base    <= base_address;
                        cfg.words   <= words_num;
                        req_cnt     <= '0;
                        ret_cnt     <= '0;
                        outstanding <= '0;
                        busy        <= 1'b1;
                        if (words_num == '0) begin
                            state   <= FINISH;
                            done    <= 1'b1;
                            done_ch <= ch_onehot(ch_sel);
                        end else begin
                            state <= (dir == DIR_FWD) ? FWD : BWD;
                        end
                    end
                end
                FWD, BWD: begin
                    if (issue)    req_cnt <= req_cnt + 1'b1;
                    if (fifo_pop) ret_cnt <= ret_cnt + 1'b1;
                    outstanding <= outstanding + CNT_W'(issue) - CNT_W'(fifo_push);
                    if (fwd_pop) begin
                        glb_w_en  <= ch_onehot(cfg.ch);
                        glb_waddr <= cfg.base + ret_cnt;
                        glb_wdata <= fifo_rdata;
                    end
                    if (last_word) begin
                        state   <= FINISH;
                        done    <= 1'b1;
                        done_ch <= ch_onehot(cfg.ch);
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GLB_DMA_STATS_EN
    // run_cnt holds the cycle count the done edge would report, so the
    // latch at the FINISH transition needs no extra adder.
    logic [31:0] run_cnt, stall_cnt;
    logic        stall;

    assign stall = active && ((more_req && !credit_ok) ||
                              ((state == BWD) && !fifo_empty && !dram_w_ready));

    always_ff @(posedge core_clk) begin
        if (reset) begin
            run_cnt     <= '0;
            stall_cnt   <= '0;
            last_cycles <= '0;
            last_stall  <= '0;
        end else if (accept) begin
            run_cnt   <= 32'd1;
            stall_cnt <= '0;
            if (words_num == '0) begin
                last_cycles <= 32'd1;
                last_stall  <= '0;
            end
        end else if (active) begin
            run_cnt <= sat_inc32(run_cnt);
            if (stall) stall_cnt <= sat_inc32(stall_cnt);
            if (last_word) begin
                last_cycles <= run_cnt;
                last_stall  <= stall_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_glb_dma_engine.sv
`timescale 1ns/1ps
module tb_glb_dma_engine;
    import glb_dma_pkg::*;

    localparam int DW = 64, AW = 20, NCH = 4, CHW = 3, DEPTH = 16;

    logic           core_clk = 1'b0, reset = 1'b1, start = 1'b0, dir = 1'b0;
    logic [CHW-1:0] ch_sel = '0;
    logic [AW-1:0]  base_address = '0, words_num = '0;
    logic           busy, done, cfg_err, dram_rd_req, glb_r_en, dram_w_en;
    logic [NCH-1:0] done_ch, glb_w_en;
    logic           dram_rd_valid = 1'b0, dram_w_ready = 1'b0;
    logic [DW-1:0]  dram_rd_data = '0, glb_rdata = '0, glb_wdata, dram_wdata;
    logic [AW-1:0]  glb_waddr, glb_raddr;
`ifdef GLB_DMA_STATS_EN
    logic [31:0]    last_cycles, last_stall;
`endif

    glb_dma_engine #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH), .CH_W(CHW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .core_clk(core_clk), .reset(reset), .start(start), .dir(dir), .ch_sel(ch_sel),
        .base_address(base_address), .words_num(words_num), .busy(busy), .done(done),
        .done_ch(done_ch), .cfg_err(cfg_err), .dram_rd_req(dram_rd_req),
        .dram_rd_valid(dram_rd_valid), .dram_rd_data(dram_rd_data), .glb_w_en(glb_w_en),
        .glb_waddr(glb_waddr), .glb_wdata(glb_wdata), .glb_r_en(glb_r_en),
        .glb_raddr(glb_raddr), .glb_rdata(glb_rdata), .dram_w_en(dram_w_en),
        .dram_wdata(dram_wdata), .dram_w_ready(dram_w_ready)
`ifdef GLB_DMA_STATS_EN
        , .last_cycles(last_cycles), .last_stall(last_stall)
`endif
    );

    always #5 core_clk = ~core_clk;

    int cyc = 0;
    always @(posedge core_clk) cyc <= cyc + 1;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- memory models ----------------
    logic [31:0] dram_salt = 32'h0, glb_salt = 32'h0;

    function automatic logic [DW-1:0] dram_word(input int k);
        return {dram_salt, 32'(k) * 32'h0100_0193 + 32'h1234};
    endfunction

    function automatic logic [DW-1:0] glb_word(input logic [AW-1:0] a);
        return {glb_salt, 12'h5A5, a};
    endfunction

    function automatic logic [NCH-1:0] ch_oh(input int ch);
        logic [NCH-1:0] v;
        v = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

    // ---------------- responder / monitor ----------------
    typedef struct { int due; logic [DW-1:0] data; } rsp_t;
    typedef struct { logic [NCH-1:0] en; logic [AW-1:0] addr; logic [DW-1:0] data; } gw_t;

    rsp_t           dram_q[$];
    gw_t            glb_wr_q[$];
    logic [AW-1:0]  rd_addr_q[$];
    logic [DW-1:0]  dram_wr_q[$];
    int             fwd_lat = 1, rdy_mode = 0, hold_until = 0, rd_issued = 0;
    int             done_cnt = 0, done_cyc = 0, cfg_err_cnt = 0, cfg_err_cyc = 0;
    int             rd_req_cnt = 0, r_en_cnt = 0, start_cyc = 0;
    logic [NCH-1:0] done_ch_last = '0;
    logic           glb_pend = 1'b0;
    logic [DW-1:0]  glb_pend_data = '0;

    initial forever begin
        @(negedge core_clk);
        // DRAM read port: fixed latency, in order
        if (dram_q.size() > 0 && dram_q[0].due <= cyc) begin
            dram_rd_valid = 1'b1;
            dram_rd_data  = dram_q[0].data;
            void'(dram_q.pop_front());
        end else begin
            dram_rd_valid = 1'b0;
            dram_rd_data  = {$urandom, $urandom};
        end
        if (dram_rd_req) begin
            dram_q.push_back('{cyc + fwd_lat, dram_word(rd_issued)});
            rd_issued++;
            rd_req_cnt++;
        end
        // GLB read port: data exactly one cycle after the strobe
        glb_rdata = glb_pend ? glb_pend_data : {$urandom, $urandom};
        glb_pend  = glb_r_en;
        if (glb_r_en) begin
            glb_pend_data = glb_word(glb_raddr);
            rd_addr_q.push_back(glb_raddr);
            r_en_cnt++;
        end
        // DRAM write port
        case (rdy_mode)
            0:       dram_w_ready = 1'b1;
            1:       dram_w_ready = ~dram_w_ready;
            2:       dram_w_ready = 1'($urandom_range(0, 1));
            default: dram_w_ready = (cyc >= hold_until);
        endcase
        if (dram_w_en && dram_w_ready) dram_wr_q.push_back(dram_wdata);
        if (|glb_w_en) glb_wr_q.push_back('{glb_w_en, glb_waddr, glb_wdata});
        if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            done_ch_last = done_ch;
        end
        if (cfg_err) begin
            cfg_err_cnt++;
            cfg_err_cyc = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clr_mon();
        dram_q.delete(); glb_wr_q.delete(); rd_addr_q.delete(); dram_wr_q.delete();
        rd_issued = 0; done_cnt = 0; cfg_err_cnt = 0; rd_req_cnt = 0; r_en_cnt = 0;
        dram_salt = $urandom; glb_salt = $urandom;
    endtask

    task automatic start_xfer(input logic d, input int ch, input logic [AW-1:0] base,
                              input int n);
        @(negedge core_clk);
        dir = d; ch_sel = CHW'(ch); base_address = base; words_num = AW'(n);
        start = 1'b1; start_cyc = cyc;
        @(negedge core_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (done_cnt == 0 && i < budget) begin
            @(posedge core_clk); #1;
            i++;
        end
        repeat (3) begin @(posedge core_clk); #1; end
    endtask

    task automatic check_xfer(input logic d, input int ch, input logic [AW-1:0] base,
                              input int n, input string tag);
        logic [AW-1:0] ea;
        chk({tag, ":done_cnt"}, done_cnt, 1);
        chk({tag, ":done_ch"}, done_ch_last, ch_oh(ch));
        chk({tag, ":busy_after"}, busy, 0);
        if (d == DIR_FWD) begin
            chk({tag, ":glb_wr_cnt"}, glb_wr_q.size(), n);
            chk({tag, ":dram_req_cnt"}, rd_req_cnt, n);
            chk({tag, ":glb_rd_cnt"}, r_en_cnt, 0);
            for (int k = 0; k < n && k < glb_wr_q.size(); k++) begin
                ea = base + AW'(k);
                chk($sformatf("%s:wen[%0d]", tag, k), glb_wr_q[k].en, ch_oh(ch));
                chk($sformatf("%s:waddr[%0d]", tag, k), glb_wr_q[k].addr, ea);
                chk($sformatf("%s:wdata[%0d]", tag, k), glb_wr_q[k].data, dram_word(k));
            end
        end else begin
            chk({tag, ":glb_rd_cnt"}, rd_addr_q.size(), n);
            chk({tag, ":dram_wr_cnt"}, dram_wr_q.size(), n);
            chk({tag, ":glb_wr_cnt"}, glb_wr_q.size(), 0);
            for (int k = 0; k < n && k < rd_addr_q.size(); k++) begin
                ea = base + AW'(k);
                chk($sformatf("%s:raddr[%0d]", tag, k), rd_addr_q[k], ea);
            end
            for (int k = 0; k < n && k < dram_wr_q.size(); k++) begin
                ea = base + AW'(k);
                chk($sformatf("%s:dwdata[%0d]", tag, k), dram_wr_q[k], glb_word(ea));
            end
        end
    endtask

    task automatic run(input logic d, input int ch, input logic [AW-1:0] base, input int n,
                       input int lat, input int rm, input string tag);
        fwd_lat = lat; rdy_mode = rm;
        clr_mon();
        start_xfer(d, ch, base, n);
        wait_done(n * 40 + 400);
        check_xfer(d, ch, base, n, tag);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int snap_ren, snap_dw, i;
        logic rd;
        int rch, rn, rl, rm;
        logic [AW-1:0] rb;

        repeat (3) @(posedge core_clk);
        #1;
        chk("rst:busy", busy, 0);
        chk("rst:done", done, 0);
        chk("rst:cfg_err", cfg_err, 0);
        chk("rst:bus", {dram_rd_req, glb_w_en, glb_r_en, dram_w_en}, 0);
        @(negedge core_clk);
        reset = 1'b0;

        run(DIR_FWD, CH_FILTER, 20'h00100, 8, 3, 0, "fwd8");
        run(DIR_BWD, CH_PSUM, 20'hFFFFE, 4, 1, 1, "bwd_wrap");

        // backpressure: DRAM write side held off for 100 cycles
        fwd_lat = 1; rdy_mode = 3;
        clr_mon();
        hold_until = cyc + 100;
        start_xfer(DIR_BWD, CH_BIAS, 20'h0A000, 40);
        i = 0;
        while (cyc < hold_until - 1 && i < 200) begin @(posedge core_clk); #1; i++; end
        snap_ren = r_en_cnt; snap_dw = dram_wr_q.size();
        chk("bp:rd_bounded", snap_ren <= DEPTH, 1);
        chk("bp:rd_fill", snap_ren, DEPTH);
        chk("bp:no_wr", snap_dw, 0);
        chk("bp:busy", busy, 1);
        wait_done(2000);
        check_xfer(DIR_BWD, CH_BIAS, 20'h0A000, 40, "bp");

        // rejected channel
        rdy_mode = 0;
        clr_mon();
        start_xfer(DIR_FWD, 5, 20'h00010, 4);
        chk("cfg:busy0", busy, 0);
        repeat (4) begin @(posedge core_clk); #1; end
        chk("cfg:err_cnt", cfg_err_cnt, 1);
        chk("cfg:err_cyc", cfg_err_cyc, start_cyc + 1);
        chk("cfg:busy1", busy, 0);
        chk("cfg:no_bus", rd_req_cnt + r_en_cnt + glb_wr_q.size(), 0);
        chk("cfg:no_done", done_cnt, 0);

        // zero-length transfer
        clr_mon();
        start_xfer(DIR_FWD, CH_IFMAP, 20'h00020, 0);
        chk("zero:busy", busy, 1);
        wait_done(20);
        chk("zero:done_cnt", done_cnt, 1);
        chk("zero:done_cyc", done_cyc, start_cyc + 1);
        chk("zero:done_ch", done_ch_last, ch_oh(CH_IFMAP));
        chk("zero:no_bus", rd_req_cnt + r_en_cnt + glb_wr_q.size() + dram_wr_q.size(), 0);
        chk("zero:busy_after", busy, 0);

        // second start while busy is ignored
        fwd_lat = 2;
        clr_mon();
        start_xfer(DIR_FWD, CH_IFMAP, 20'h00200, 12);
        repeat (3) @(negedge core_clk);
        dir = DIR_BWD; ch_sel = 3'd2; base_address = 20'h00005; words_num = 20'd3;
        start = 1'b1;
        @(negedge core_clk);
        start = 1'b0;
        wait_done(600);
        check_xfer(DIR_FWD, CH_IFMAP, 20'h00200, 12, "restart");
        chk("restart:no_err", cfg_err_cnt, 0);

        // reset in the middle of a transfer
        fwd_lat = 2;
        clr_mon();
        start_xfer(DIR_FWD, CH_BIAS, 20'h03000, 20);
        i = 0;
        while (glb_wr_q.size() < 5 && i < 200) begin @(posedge core_clk); #1; i++; end
        chk("mid_rst:reach5", glb_wr_q.size() >= 5, 1);
        @(negedge core_clk);
        reset = 1'b1;
        @(posedge core_clk); #1;
        chk("mid_rst:ctl0", {busy, done, done_ch, cfg_err}, 0);
        chk("mid_rst:bus0", |{dram_rd_req, glb_w_en, glb_waddr, glb_wdata, glb_r_en,
                              glb_raddr, dram_w_en, dram_wdata}, 0);
        @(negedge core_clk);
        reset = 1'b0;
        repeat (20) begin @(posedge core_clk); #1; end
        chk("mid_rst:no_done", done_cnt, 0);
        chk("mid_rst:idle", busy, 0);
        run(DIR_FWD, CH_BIAS, 20'h03000, 20, 2, 0, "post_rst");

        // randomized transfers
        for (int t = 0; t < 8; t++) begin
            rd  = 1'($urandom_range(0, 1));
            rch = $urandom_range(0, NCH - 1);
            rb  = AW'($urandom);
            rn  = $urandom_range(1, 30);
            rl  = $urandom_range(1, 4);
            rm  = $urandom_range(0, 2);
            run(rd, rch, rb, rn, rl, rm, $sformatf("rnd%0d", t));
        end

`ifdef GLB_DMA_STATS_EN
        // no-stall forward: n requests, lat cycles of DRAM latency, one pop
        // cycle, one FINISH-decision cycle
        run(DIR_FWD, CH_FILTER, 20'h00400, 8, 1, 0, "stats");
        chk("stats:last_stall", last_stall, 0);
        chk("stats:last_cycles", last_cycles, 8 + 1 + 2);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_err);
        $fatal(1);
    end

endmodule
